// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - shared types and constants for the TX frame scheduler
// Contents:
//   HDR_WIDTH      width of the frame type header at the top of frame_out
//   frame_type_e   frame type header encoding (IDLE/DATA/CTRL)
//   sched_state_e  scheduler FSM states (INIT/RUN)
package tx_sched_pkg;

    localparam int HDR_WIDTH = 2;

    typedef enum logic [HDR_WIDTH-1:0] {
        FT_IDLE = 2'b00,
        FT_DATA = 2'b01,
        FT_CTRL = 2'b10
    } frame_type_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/tx_sched_arb.sv
// rtl/tx_sched_arb.sv - combinational slot arbiter with control-run starvation limit
// Ports:
//   i_ctrl_req  control frame requested
//   i_data_ok   data frame eligible (valid and not paused)
//   i_run_cnt   consecutive control frames sent while data was eligible
//   o_sel       frame type chosen for the current decision cycle
module tx_sched_arb
    import tx_sched_pkg::*;
#(
    parameter int MAX_CTRL_RUN = 3,
    parameter int RUN_W        = 2
) (
    input  logic             i_ctrl_req,
    input  logic             i_data_ok,
    input  logic [RUN_W-1:0] i_run_cnt,
    output frame_type_e      o_sel
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CTRL_RUN);

    // Control wins until it has held data off for RUN_MAX frames in a row;
    // with no eligible data it always wins.
    always_comb begin
        o_sel = FT_IDLE;
        if (i_ctrl_req && ((i_run_cnt < RUN_MAX) || !i_data_ok)) begin
            o_sel = FT_CTRL;
        end else if (i_data_ok) begin
            o_sel = FT_DATA;
        end else if (i_ctrl_req) begin
            o_sel = FT_CTRL;
        end
    end

endmodule

// File: rtl/tx_frame_sched.sv
// rtl/tx_frame_sched.sv - TX frame scheduler: picks an idle/data/control frame once per frame period
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   s_axis_tdata/tvalid    data payload; s_axis_tready pulses in the accepting decision cycle
//   ctrl_payload/ctrl_req  control payload; ctrl_ack pulses in the accepting decision cycle
//   pause                  remote backpressure, blocks data frames only
//   clk_cnt                frame phase count to the width converter
//   frame_out              {type, payload}, updated only on the edge ending a decision cycle
//   link_up                high once the initial idle sequence has completed
module tx_frame_sched
    import tx_sched_pkg::*;
#(
    parameter int FRAME_WIDTH  = 256,
    parameter int CNT_WIDTH    = 2,
    parameter int INIT_FRAMES  = 16,
    parameter int MAX_CTRL_RUN = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FRAME_WIDTH-HDR_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [FRAME_WIDTH-HDR_WIDTH-1:0] ctrl_payload,
    input  logic                           ctrl_req,
    output logic                           ctrl_ack,
    input  logic                           pause,
    output logic [CNT_WIDTH-1:0]           clk_cnt,
    output logic [FRAME_WIDTH-1:0]         frame_out,
    output logic                           link_up
);

    localparam int PW     = FRAME_WIDTH - HDR_WIDTH;
    localparam int INIT_W = (INIT_FRAMES > 1) ? $clog2(INIT_FRAMES) : 1;
    localparam int RUN_W  = (MAX_CTRL_RUN > 0) ? $clog2(MAX_CTRL_RUN + 1) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = '1;
    localparam logic [INIT_W-1:0]    INIT_LAST = INIT_W'(INIT_FRAMES - 1);
    localparam logic [RUN_W-1:0]     RUN_MAX   = RUN_W'(MAX_CTRL_RUN);

    sched_state_e         r_state;
    logic [CNT_WIDTH-1:0] r_clk_cnt;
    logic [INIT_W-1:0]    r_init_cnt;
    logic [RUN_W-1:0]     r_run_cnt;
    logic [FRAME_WIDTH-1:0] r_frame;

    sched_state_e         w_state_nxt;
    logic                 w_decision;
    logic                 w_data_ok;
    frame_type_e          w_sel;
    logic [PW-1:0]        w_payload;

    assign w_decision = (r_clk_cnt == CNT_LAST);
    assign w_data_ok  = s_axis_tvalid && !pause;
    assign clk_cnt    = r_clk_cnt;
    assign frame_out  = r_frame;

    tx_sched_arb #(
        .MAX_CTRL_RUN (MAX_CTRL_RUN),
        .RUN_W        (RUN_W)
    ) u_arb (
        .i_ctrl_req (ctrl_req),
        .i_data_ok  (w_data_ok),
        .i_run_cnt  (r_run_cnt),
        .o_sel      (w_sel)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state; INIT ends on the decision cycle of the last idle frame
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_INIT) && w_decision && (r_init_cnt == INIT_LAST)) begin
            w_state_nxt = ST_RUN;
        end
    end

    // FSM: outputs; handshakes are masked by rst so a reset landing on a
    // decision cycle leaves pending requests unacknowledged
    always_comb begin
        link_up       = (r_state == ST_RUN);
        s_axis_tready = 1'b0;
        ctrl_ack      = 1'b0;
        if ((r_state == ST_RUN) && w_decision && !rst) begin
            s_axis_tready = (w_sel == FT_DATA);
            ctrl_ack      = (w_sel == FT_CTRL);
        end
    end

    always_comb begin
        w_payload = '0;
        case (w_sel)
            FT_DATA: w_payload = s_axis_tdata;
            FT_CTRL: w_payload = ctrl_payload;
            default: w_payload = '0;
        endcase
    end

    // Phase counter, INIT frame counter, control run counter and frame register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt  <= '0;
            r_init_cnt <= '0;
            r_run_cnt  <= '0;
            r_frame    <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
            if (w_decision) begin
                if (r_state == ST_INIT) begin
                    r_frame <= '0;
                    if (r_init_cnt != INIT_LAST) begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end else begin
                    r_frame <= {w_sel, w_payload};
                    if (w_sel == FT_CTRL) begin
                        // Control sent with no data waiting is not starving anyone
                        if (w_data_ok && (r_run_cnt != RUN_MAX)) begin
                            r_run_cnt <= r_run_cnt + 1'b1;
                        end
                    end else begin
                        r_run_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// tb/tb_tx_frame_sched.sv - self-checking bench for tx_frame_sched
module tb_tx_frame_sched;

    localparam int FW          = 256;
    localparam int CW          = 2;
    localparam int PERIOD      = 4;
    localparam int INIT_FRAMES = 16;
    localparam int MAX_RUN     = 3;
    localparam int PW          = FW - 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [PW-1:0] ctrl_payload;
    logic          ctrl_req;
    logic          ctrl_ack;
    logic          pause;
    logic [CW-1:0] clk_cnt;
    logic [FW-1:0] frame_out;
    logic          link_up;

    int n_vec = 0;
    int n_err = 0;

    tx_frame_sched #(
        .FRAME_WIDTH  (FW),
        .CNT_WIDTH    (CW),
        .INIT_FRAMES  (INIT_FRAMES),
        .MAX_CTRL_RUN (MAX_RUN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .ctrl_payload  (ctrl_payload),
        .ctrl_req      (ctrl_req),
        .ctrl_ack      (ctrl_ack),
        .pause         (pause),
        .clk_cnt       (clk_cnt),
        .frame_out     (frame_out),
        .link_up       (link_up)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Time is counted in cycles since reset; the frame slot and link status
    // follow from that count and from how many idle frames INIT has sent.
    int            m_cycle = 0;
    int            m_init_frames = 0;
    int            m_run = 0;
    logic [FW-1:0] m_frame = '0;
    logic [CW-1:0] m_cnt;
    logic          m_dec, m_link, m_elig, exp_ready, exp_ack;
    int            m_choice;

    // 0 = IDLE, 1 = DATA, 2 = CTRL
    function automatic int pick(input logic req, input logic elig, input int run);
        if (req && (run < MAX_RUN || !elig)) return 2;
        if (elig) return 1;
        if (req) return 2;
        return 0;
    endfunction

    always_comb begin
        m_cnt     = CW'(m_cycle % PERIOD);
        m_dec     = ((m_cycle % PERIOD) == PERIOD - 1);
        m_link    = (m_init_frames >= INIT_FRAMES);
        m_elig    = s_axis_tvalid && !pause;
        m_choice  = pick(ctrl_req, m_elig, m_run);
        exp_ready = !rst && m_dec && m_link && (m_choice == 1);
        exp_ack   = !rst && m_dec && m_link && (m_choice == 2);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_cycle       = 0;
            m_init_frames = 0;
            m_run         = 0;
            m_frame       = '0;
        end else begin
            if (m_dec) begin
                if (!m_link) begin
                    m_init_frames = m_init_frames + 1;
                    m_frame       = '0;
                end else if (m_choice == 1) begin
                    m_frame = {2'b01, s_axis_tdata};
                    m_run   = 0;
                end else if (m_choice == 2) begin
                    m_frame = {2'b10, ctrl_payload};
                    if (m_elig) m_run = (m_run + 1 > MAX_RUN) ? MAX_RUN : m_run + 1;
                end else begin
                    m_frame = '0;
                    m_run   = 0;
                end
            end
            m_cycle = m_cycle + 1;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [PW-1:0] rnd_payload();
        logic [PW-1:0] v = '0;
        for (int i = 0; i < (PW + 31) / 32; i++) v = {v[PW-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [PW-1:0] a5_pattern();
        logic [7:0]    b = 8'hA5;
        logic [PW-1:0] v = '0;
        for (int i = 0; i < PW; i++) v[i] = b[i % 8];
        return v;
    endfunction

    task automatic align(input int target);
        for (int k = 0; k < 2 * PERIOD && clk_cnt !== CW'(target); k++) @(negedge clk);
        n_vec++;
        if (clk_cnt !== CW'(target)) begin
            n_err++;
            $display("FAIL align got clk_cnt=%0d want %0d", clk_cnt, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; s_axis_tvalid = 1'b1; ctrl_req = 1'b1; pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({clk_cnt, frame_out, s_axis_tready, ctrl_ack, link_up} !== '0) begin
                n_err++;
                $display("FAIL reset_state cnt=%0d rdy=%b ack=%b link=%b frame=%h want all 0",
                         clk_cnt, s_axis_tready, ctrl_ack, link_up, frame_out);
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            s_axis_tdata = rnd_payload(); ctrl_payload = rnd_payload();
            @(negedge clk);
            n_vec++;
            if ({clk_cnt, link_up, s_axis_tready, ctrl_ack} !== {m_cnt, m_link, exp_ready, exp_ack}) begin
                n_err++;
                $display("FAIL reset_ctl c=%0d got cnt/link/rdy/ack=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         c, clk_cnt, link_up, s_axis_tready, ctrl_ack, m_cnt, m_link, exp_ready, exp_ack);
            end
            n_vec++;
            if (frame_out !== m_frame) begin
                n_err++;
                $display("FAIL reset_frame c=%0d got %h want %h", c, frame_out, m_frame);
            end
            if (c < 64) begin
                n_vec++;
                if ({link_up, s_axis_tready, ctrl_ack} !== 3'b000 || frame_out !== '0) begin
                    n_err++;
                    $display("FAIL init_idle c=%0d link=%b rdy=%b ack=%b hdr=%b want 0/0/0/00",
                             c, link_up, s_axis_tready, ctrl_ack, frame_out[FW-1 -: 2]);
                end
            end
            if (c == 64) begin
                n_vec++;
                if (link_up !== 1'b1) begin
                    n_err++;
                    $display("FAIL link_up_at_64 got %b want 1", link_up);
                end
            end
            if (c == 67) begin
                n_vec++;
                if ({ctrl_ack, s_axis_tready} !== 2'b10) begin
                    n_err++;
                    $display("FAIL first_ack got ack/rdy=%b/%b want 1/0", ctrl_ack, s_axis_tready);
                end
            end
            if (c == 68) begin
                n_vec++;
                if (frame_out[FW-1 -: 2] !== 2'b10) begin
                    n_err++;
                    $display("FAIL first_frame_ctrl got hdr %b want 10", frame_out[FW-1 -: 2]);
                end
            end
        end
    endtask

    task automatic test_data_stream();
        logic [PW-1:0] a5 = a5_pattern();
        int rdy = 0;
        ctrl_req = 1'b0; pause = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = a5;
        align(0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_vec++;
            if ({clk_cnt, link_up, s_axis_tready, ctrl_ack} !== {m_cnt, m_link, exp_ready, exp_ack}) begin
                n_err++;
                $display("FAIL data_ctl k=%0d got cnt/link/rdy/ack=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         k, clk_cnt, link_up, s_axis_tready, ctrl_ack, m_cnt, m_link, exp_ready, exp_ack);
            end
            n_vec++;
            if (s_axis_tready !== (clk_cnt == 2'd3)) begin
                n_err++;
                $display("FAIL data_ready_phase cnt=%0d got %b want %b", clk_cnt, s_axis_tready, clk_cnt == 2'd3);
            end
            if (s_axis_tready === 1'b1) rdy++;
            if (clk_cnt == 2'd0) begin
                n_vec++;
                if (frame_out !== {2'b01, a5}) begin
                    n_err++;
                    $display("FAIL data_frame got %h want %h", frame_out, {2'b01, a5});
                end
            end
        end
        n_vec++;
        if (rdy != 8) begin
            n_err++;
            $display("FAIL data_ready_count got %0d want 8", rdy);
        end
    endtask

    task automatic test_ctrl_starve();
        int acks = 0, rdys = 0, nd = 0;
        align(0);
        ctrl_req = 1'b1; s_axis_tvalid = 1'b1; pause = 1'b0;
        for (int k = 0; k < 64; k++) begin
            s_axis_tdata = rnd_payload(); ctrl_payload = rnd_payload();
            @(negedge clk);
            n_vec++;
            if ({clk_cnt, link_up, s_axis_tready, ctrl_ack} !== {m_cnt, m_link, exp_ready, exp_ack}) begin
                n_err++;
                $display("FAIL starve_ctl k=%0d got cnt/link/rdy/ack=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         k, clk_cnt, link_up, s_axis_tready, ctrl_ack, m_cnt, m_link, exp_ready, exp_ack);
            end
            n_vec++;
            if (frame_out !== m_frame) begin
                n_err++;
                $display("FAIL starve_frame k=%0d got %h want %h", k, frame_out, m_frame);
            end
            if (clk_cnt == 2'd3) begin
                n_vec++;
                if ({s_axis_tready, ctrl_ack} !== ((nd % 4 == 3) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL starve_pattern slot=%0d got rdy/ack=%b/%b", nd, s_axis_tready, ctrl_ack);
                end
                nd++;
            end
            if (ctrl_ack === 1'b1) acks++;
            if (s_axis_tready === 1'b1) rdys++;
        end
        n_vec++;
        if (acks != 12 || rdys != 4) begin
            n_err++;
            $display("FAIL starve_counts got ack/ready=%0d/%0d want 12/4", acks, rdys);
        end
    endtask

    task automatic test_pause();
        align(0);
        ctrl_req = 1'b0; s_axis_tvalid = 1'b1; pause = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_vec++;
            if (s_axis_tready !== 1'b0 || ctrl_ack !== 1'b0) begin
                n_err++;
                $display("FAIL pause_block k=%0d got rdy/ack=%b/%b want 0/0", k, s_axis_tready, ctrl_ack);
            end
            if (clk_cnt == 2'd0) begin
                n_vec++;
                if (frame_out !== '0) begin
                    n_err++;
                    $display("FAIL pause_idle_frame got %h want 0", frame_out);
                end
            end
        end
        align(2);
        pause = 1'b0;
        s_axis_tdata = rnd_payload();
        @(negedge clk);
        n_vec++;
        if (s_axis_tready !== 1'b1 || clk_cnt !== 2'd3) begin
            n_err++;
            $display("FAIL pause_release_ready got rdy=%b cnt=%0d want 1/3", s_axis_tready, clk_cnt);
        end
        @(negedge clk);
        n_vec++;
        if (frame_out !== {2'b01, s_axis_tdata}) begin
            n_err++;
            $display("FAIL pause_release_frame got %h want %h", frame_out, {2'b01, s_axis_tdata});
        end
    endtask

    task automatic test_ctrl_pulse();
        s_axis_tvalid = 1'b0; pause = 1'b0; ctrl_req = 1'b0;
        for (int rep = 0; rep < 3; rep++) begin
            align(1);
            ctrl_req = 1'b1; ctrl_payload = rnd_payload();
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                ctrl_req = 1'b0;
                n_vec++;
                if (ctrl_ack !== 1'b0 || s_axis_tready !== 1'b0) begin
                    n_err++;
                    $display("FAIL pulse_no_ack rep=%0d got ack/rdy=%b/%b want 0/0", rep, ctrl_ack, s_axis_tready);
                end
                if (clk_cnt == 2'd0) begin
                    n_vec++;
                    if (frame_out !== '0) begin
                        n_err++;
                        $display("FAIL pulse_no_frame rep=%0d got hdr %b want 00", rep, frame_out[FW-1 -: 2]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            s_axis_tvalid = ($urandom % 4) != 0;
            ctrl_req      = ($urandom % 3) == 0;
            pause         = ($urandom % 5) == 0;
            s_axis_tdata  = rnd_payload();
            ctrl_payload  = rnd_payload();
            @(negedge clk);
            n_vec++;
            if ({clk_cnt, link_up, s_axis_tready, ctrl_ack} !== {m_cnt, m_link, exp_ready, exp_ack}) begin
                n_err++;
                $display("FAIL random_ctl k=%0d got cnt/link/rdy/ack=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         k, clk_cnt, link_up, s_axis_tready, ctrl_ack, m_cnt, m_link, exp_ready, exp_ack);
            end
            n_vec++;
            if (frame_out !== m_frame) begin
                n_err++;
                $display("FAIL random_frame k=%0d got %h want %h", k, frame_out, m_frame);
            end
        end
    endtask

    task automatic test_mid_reset();
        s_axis_tvalid = 1'b1; ctrl_req = 1'b1; pause = 1'b0;
        align(2);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({clk_cnt, frame_out, link_up, s_axis_tready, ctrl_ack} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_state cnt=%0d link=%b rdy=%b ack=%b frame=%h want all 0",
                     clk_cnt, link_up, s_axis_tready, ctrl_ack, frame_out);
        end
        rst = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            n_vec++;
            if ({clk_cnt, link_up, s_axis_tready, ctrl_ack} !== {m_cnt, m_link, exp_ready, exp_ack}) begin
                n_err++;
                $display("FAIL mid_reset_ctl c=%0d got cnt/link/rdy/ack=%0d/%b/%b/%b want %0d/%b/%b/%b",
                         c, clk_cnt, link_up, s_axis_tready, ctrl_ack, m_cnt, m_link, exp_ready, exp_ack);
            end
            if (c < 64) begin
                n_vec++;
                if ({link_up, s_axis_tready, ctrl_ack} !== 3'b000 || frame_out !== '0) begin
                    n_err++;
                    $display("FAIL mid_reset_init c=%0d link=%b rdy=%b ack=%b want 0/0/0 idle",
                             c, link_up, s_axis_tready, ctrl_ack);
                end
            end
            if (c == 64) begin
                n_vec++;
                if (link_up !== 1'b1) begin
                    n_err++;
                    $display("FAIL mid_reset_link got %b want 1", link_up);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; s_axis_tvalid = 1'b0; ctrl_req = 1'b0; pause = 1'b0;
        s_axis_tdata = '0; ctrl_payload = '0;
        test_reset();
        test_data_stream();
        test_ctrl_starve();
        test_pause();
        test_ctrl_pulse();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter FRAME_WIDTH, default 256: width of the wide frame presented to the TX width converter.
REQ-002 Parameter CNT_WIDTH, default 2: width of the phase count; PERIOD = 2**CNT_WIDTH beats per frame.
REQ-003 Parameter INIT_FRAMES, default 16: number of idle frames sent after reset before any data or control frame.
REQ-004 Parameter MAX_CTRL_RUN, default 3: maximum consecutive control frames while data is waiting.
REQ-005 Port clk, input, 1: single clock.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port s_axis_tdata, input, FRAME_WIDTH-2: data payload.
REQ-008 Port s_axis_tvalid / s_axis_tready, input / output, 1 each: data handshake.
REQ-009 Port ctrl_payload, input, FRAME_WIDTH-2: control frame payload.
REQ-010 Port ctrl_req / ctrl_ack, input / output, 1 each: control request and one-cycle acknowledge.
REQ-011 Port pause, input, 1: remote backpressure; blocks data frames only.
REQ-012 Port clk_cnt, output, CNT_WIDTH: frame phase count driven to the width converter.
REQ-013 Port frame_out, output, FRAME_WIDTH: {2-bit type, payload}; type IDLE=2'b00, DATA=2'b01, CTRL=2'b10.
REQ-014 Port link_up, output, 1: high once the INIT state has completed.

Function
REQ-015 clk_cnt SHALL increment by 1 every cycle and wrap from PERIOD-1 to 0.
REQ-016 The decision cycle SHALL be the cycle with clk_cnt==PERIOD-1; frame_out SHALL change only on the clock edge that ends a decision cycle, so it is stable for the entire cycle with clk_cnt==0.
REQ-017 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-018 In INIT every frame SHALL be IDLE with an all-zero payload, a frame counter SHALL count decision cycles, and the FSM SHALL move to RUN after INIT_FRAMES idle frames.
REQ-019 link_up SHALL be 0 in INIT and 1 in RUN.
REQ-020 RUN arbitration at each decision cycle, in priority order:
- ctrl_req && (run_cnt < MAX_CTRL_RUN || !(s_axis_tvalid && !pause)) -> CTRL.
- else s_axis_tvalid && !pause -> DATA.
- else ctrl_req -> CTRL.
- else IDLE.
REQ-021 run_cnt SHALL increment on each CTRL frame sent while data is eligible (s_axis_tvalid && !pause), saturate at MAX_CTRL_RUN, and clear on any DATA or IDLE frame.
REQ-022 s_axis_tready SHALL be high only in a decision cycle in which DATA is selected; s_axis_tdata is captured on that edge.
REQ-023 ctrl_ack SHALL be high only in a decision cycle in which CTRL is selected; ctrl_payload is captured on that edge.
REQ-024 s_axis_tready and ctrl_ack SHALL never both be high, and neither SHALL be high outside decision cycles or in INIT.
REQ-025 Requests deasserted before the decision cycle SHALL be ignored, with no ack and no frame.
REQ-026 pause asserted in a decision cycle SHALL block DATA for that frame only; CTRL SHALL still be sent.
REQ-027 Latency from acceptance to the frame appearing on frame_out SHALL be exactly 1 cycle.

Reset
REQ-028 On rst, the following SHALL hold on the next edge:
- clk_cnt=0, FSM=INIT, init counter=0, run_cnt=0.
- frame_out=all zeros (IDLE).
- s_axis_tready=0, ctrl_ack=0, link_up=0.
REQ-029 Reset mid-frame or mid-RUN SHALL abandon the current slot and restart INIT; pending requests SHALL remain unacknowledged.

Structure
REQ-030 Package tx_sched_pkg SHALL hold:
- frame type enum (IDLE/DATA/CTRL) and its 2-bit encoding;
- FSM state enum;
- HDR_WIDTH=2 constant.
REQ-031 One sub-module, tx_sched_arb, SHALL implement the combinational priority and starvation decision of REQ-020; the counters and FSM SHALL stay in tx_frame_sched.

Verification
REQ-032 Reset with INIT_FRAMES=16, PERIOD=4, and data and ctrl both held valid -> 64 cycles of IDLE frames with no ready/ack and link_up=0; link_up=1 at cycle 64, then the first non-idle frame is CTRL.
REQ-033 In RUN, s_axis_tvalid held with tdata=0xA5.., no ctrl -> tready pulses every 4th cycle (clk_cnt==3); frame_out=DATA with header 2'b01 during clk_cnt==0.
REQ-034 ctrl_req and tvalid both held continuously -> repeating pattern CTRL, CTRL, CTRL, DATA; ack/ready counts per 16 frames are 12/4.
REQ-035 pause=1 with tvalid=1 and ctrl_req=0 -> IDLE frames and tready stays 0; pause cleared one cycle before a decision cycle -> DATA sent in that slot.
REQ-036 rst asserted at clk_cnt==2 in RUN -> clk_cnt=0, frame_out=0 and link_up=0 on the next edge; INIT repeats in full.
REQ-037 ctrl_req pulsed at clk_cnt==1 only -> no ctrl_ack and no CTRL frame.
